// File: rtl/dds_mod_core.sv
`default_nettype none
// ============================================================================
// dds_mod_core : multi-mode DDS core (carrier / AM / FM / PM / tone) with
//                sample-aligned shadow config and a fixed 4-stage pipeline.
// Rev 1.0
// ============================================================================
module dds_mod_core #(
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int LUT_AW = 8,
    parameter int MA_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    cfg_load,
    input  logic [2:0]              cfg_mode,
    input  logic [ACC_W-1:0]        cfg_fc,
    input  logic [ACC_W-1:0]        cfg_fs,
    input  logic [ACC_W-1:0]        cfg_fd,
    input  logic [MA_W-1:0]         cfg_ma,
    input  logic                    cfg_sync,
    output logic                    cfg_ack,
    output logic signed [OUT_W-1:0] sig_out,
    output logic                    sig_valid
);

    localparam logic [2:0] c_MODE_CAR  = 3'd0;
    localparam logic [2:0] c_MODE_AM   = 3'd1;
    localparam logic [2:0] c_MODE_FM   = 3'd2;
    localparam logic [2:0] c_MODE_PM   = 3'd3;
    localparam logic [2:0] c_MODE_TONE = 3'd4;
    localparam int         c_PW        = ACC_W + OUT_W;
    localparam int         c_MW        = 2*OUT_W + MA_W + 2;

    // Quarter-wave table entry, evaluated at elaboration by a Taylor series.
    function automatic logic [OUT_W-1:0] f_lut(input int k);
        real x, term, s;
        x    = 3.14159265358979323846 * (real'(k) + 0.5) / real'(2**(LUT_AW+1));
        s    = x;
        term = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2*n) * (2*n + 1));
            s    = s + term;
        end
        return OUT_W'($rtoi(s * real'(2**(OUT_W-1) - 1) + 0.5));
    endfunction

    logic signed [OUT_W-1:0] w_lut [2**LUT_AW];

    for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_lut
        localparam logic signed [OUT_W-1:0] c_LUT_VAL = f_lut(k);
        assign w_lut[k] = c_LUT_VAL;
    end

    // Shadow / active configuration
    logic [2:0]       r_sh_mode, r_mode;
    logic [ACC_W-1:0] r_sh_fc, r_sh_fs, r_sh_fd, r_fc, r_fs, r_fd;
    logic [MA_W-1:0]  r_sh_ma, r_ma;
    logic             r_sh_sync, r_pend, r_ack;

    // Accumulators and modulating-sample feedback
    logic [ACC_W-1:0]        r_ph_c, r_ph_m;
    logic signed [OUT_W-1:0] r_mq;

    // Pipeline
    logic                    r_v1, r_v2, r_v3, r_vo;
    logic [LUT_AW+1:0]       r_p1_c, r_p1_m;
    logic [2:0]              r_mode1, r_mode2, r_mode3;
    logic [MA_W-1:0]         r_ma1, r_ma2, r_ma3;
    logic [LUT_AW-1:0]       r_i2_c, r_i2_m;
    logic                    r_neg2_c, r_neg2_m;
    logic signed [OUT_W-1:0] r_c3, r_m3, r_out;

    logic                    w_apply;
    logic signed [c_PW-1:0]  w_mq_ext, w_fd_ext, w_prod;
    logic [ACC_W-1:0]        w_dev, w_inc, w_phc_look;
    logic signed [OUT_W-1:0] w_sin_c, w_sin_m, w_mix;
    logic signed [c_MW-1:0]  w_c_ext, w_m_ext, w_ma_ext, w_cm, w_am;

    // A load in the same cycle as en defers the apply to the next en.
    assign w_apply = en & r_pend & ~cfg_load;

    assign w_mq_ext   = {{ACC_W{r_mq[OUT_W-1]}}, r_mq};
    assign w_fd_ext   = {{OUT_W{1'b0}}, r_fd};
    assign w_prod     = w_mq_ext * w_fd_ext;
    assign w_dev      = ACC_W'(w_prod >>> (OUT_W-1));
    assign w_inc      = (r_mode == c_MODE_FM) ? r_fc + w_dev : r_fc;
    assign w_phc_look = r_ph_c + ((r_mode == c_MODE_PM) ? w_dev : '0);

    assign w_sin_c = r_neg2_c ? -w_lut[r_i2_c] : w_lut[r_i2_c];
    assign w_sin_m = r_neg2_m ? -w_lut[r_i2_m] : w_lut[r_i2_m];

    assign w_c_ext  = {{(c_MW-OUT_W){r_c3[OUT_W-1]}}, r_c3};
    assign w_m_ext  = {{(c_MW-OUT_W){r_m3[OUT_W-1]}}, r_m3};
    assign w_ma_ext = {{(c_MW-MA_W){1'b0}}, r_ma3};
    assign w_cm     = w_c_ext * w_m_ext;
    assign w_am     = ((w_c_ext <<< MA_W) + (w_cm >>> (OUT_W-1)) * w_ma_ext) >>> (MA_W+1);

    always_comb begin
        w_mix = '0;
        case (r_mode3)
            c_MODE_CAR, c_MODE_FM, c_MODE_PM: w_mix = r_c3;
            c_MODE_AM:                        w_mix = OUT_W'(w_am);
            c_MODE_TONE:                      w_mix = r_m3;
            default:                          w_mix = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_mode <= '0; r_sh_fc <= '0; r_sh_fs <= '0; r_sh_fd <= '0;
            r_sh_ma   <= '0; r_sh_sync <= 1'b0; r_pend <= 1'b0; r_ack <= 1'b0;
            r_mode    <= '0; r_fc <= '0; r_fs <= '0; r_fd <= '0; r_ma <= '0;
            r_ph_c    <= '0; r_ph_m <= '0; r_mq <= '0;
            r_v1      <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0; r_vo <= 1'b0;
            r_p1_c    <= '0; r_p1_m <= '0; r_mode1 <= '0; r_ma1 <= '0;
            r_i2_c    <= '0; r_i2_m <= '0; r_neg2_c <= 1'b0; r_neg2_m <= 1'b0;
            r_mode2   <= '0; r_ma2 <= '0;
            r_c3      <= '0; r_m3 <= '0; r_mode3 <= '0; r_ma3 <= '0;
            r_out     <= '0;
        end else begin
            if (cfg_load) begin
                r_sh_mode <= cfg_mode; r_sh_fc <= cfg_fc; r_sh_fs <= cfg_fs;
                r_sh_fd   <= cfg_fd;   r_sh_ma <= cfg_ma; r_sh_sync <= cfg_sync;
                r_pend    <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
            if (w_apply) begin
                r_mode <= r_sh_mode; r_fc <= r_sh_fc; r_fs <= r_sh_fs;
                r_fd   <= r_sh_fd;   r_ma <= r_sh_ma;
            end
            r_ack <= w_apply;

            // The applying tick still advances with the old active config.
            if (en) begin
                if (w_apply && r_sh_sync) begin
                    r_ph_c <= '0;
                    r_ph_m <= '0;
                end else begin
                    r_ph_c <= r_ph_c + w_inc;
                    r_ph_m <= r_ph_m + r_fs;
                end
            end

            r_v1    <= en;
            r_p1_c  <= (LUT_AW+2)'(w_phc_look >> (ACC_W-LUT_AW-2));
            r_p1_m  <= (LUT_AW+2)'(r_ph_m >> (ACC_W-LUT_AW-2));
            r_mode1 <= r_mode;
            r_ma1   <= r_ma;

            r_v2     <= r_v1;
            r_i2_c   <= r_p1_c[LUT_AW-1:0] ^ {LUT_AW{r_p1_c[LUT_AW]}};
            r_i2_m   <= r_p1_m[LUT_AW-1:0] ^ {LUT_AW{r_p1_m[LUT_AW]}};
            r_neg2_c <= r_p1_c[LUT_AW+1];
            r_neg2_m <= r_p1_m[LUT_AW+1];
            r_mode2  <= r_mode1;
            r_ma2    <= r_ma1;

            r_v3    <= r_v2;
            r_c3    <= w_sin_c;
            r_m3    <= w_sin_m;
            r_mode3 <= r_mode2;
            r_ma3   <= r_ma2;
            if (r_v2) begin
                r_mq <= w_sin_m;
            end

            r_vo <= r_v3;
            if (r_v3) begin
                r_out <= w_mix;
            end
        end
    end

    assign cfg_ack   = r_ack;
    assign sig_out   = r_out;
    assign sig_valid = r_vo;

endmodule
`default_nettype wire

// File: tb/tb_dds_mod_core.sv
`default_nettype none
// ============================================================================
// tb_dds_mod_core : scoreboard bench for dds_mod_core against a tick model.
// Rev 1.0
// ============================================================================
module tb_dds_mod_core;

    localparam int ACC_W  = 32;
    localparam int OUT_W  = 16;
    localparam int LUT_AW = 8;
    localparam int MA_W   = 4;

    logic                    clk = 1'b0;
    logic                    rst, en, cfg_load, cfg_sync;
    logic [2:0]              cfg_mode;
    logic [ACC_W-1:0]        cfg_fc, cfg_fs, cfg_fd;
    logic [MA_W-1:0]         cfg_ma;
    logic                    cfg_ack, sig_valid;
    logic signed [OUT_W-1:0] sig_out;

    always #5 clk = ~clk;

    dds_mod_core #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .LUT_AW(LUT_AW),
        .MA_W  (MA_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_load (cfg_load),
        .cfg_mode (cfg_mode),
        .cfg_fc   (cfg_fc),
        .cfg_fs   (cfg_fs),
        .cfg_fd   (cfg_fd),
        .cfg_ma   (cfg_ma),
        .cfg_sync (cfg_sync),
        .cfg_ack  (cfg_ack),
        .sig_out  (sig_out),
        .sig_valid(sig_valid)
    );

    typedef struct { logic signed [OUT_W-1:0] val; int due; } sb_t;
    typedef struct { int t; int m; } hist_t;

    sb_t   sbq[$];
    int    ackq[$];
    hist_t hist[$];
    int    n_chk = 0, n_fail = 0, cyc = 0;
    bit    mon_on = 1'b0;
    logic signed [OUT_W-1:0] last_out;
    int    lut[2**LUT_AW];

    // Reference model state
    logic [ACC_W-1:0] m_phc, m_phm, a_fc, a_fs, a_fd, s_fc, s_fs, s_fd;
    int               a_mode, a_ma, s_mode, s_ma, mq;
    bit               s_sync, pend;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int msin(input logic [ACC_W-1:0] ph);
        logic [LUT_AW-1:0] idx;
        int v;
        idx = ph[ACC_W-3 -: LUT_AW];
        if (ph[ACC_W-2]) idx = ~idx;
        v = lut[idx];
        return ph[ACC_W-1] ? -v : v;
    endfunction

    function automatic logic [ACC_W-1:0] mdev();
        longint p;
        p = longint'(mq) * longint'({32'd0, a_fd});
        p = p >>> (OUT_W-1);
        return p[ACC_W-1:0];
    endfunction

    task automatic set_cfg(input int mode, input logic [ACC_W-1:0] fc, input logic [ACC_W-1:0] fs,
                           input logic [ACC_W-1:0] fd, input int ma, input bit sync);
        cfg_mode = mode[2:0]; cfg_fc = fc; cfg_fs = fs; cfg_fd = fd;
        cfg_ma = ma[MA_W-1:0]; cfg_sync = sync;
    endtask

    task automatic clear_model();
        m_phc = '0; m_phm = '0; a_fc = '0; a_fs = '0; a_fd = '0;
        s_fc = '0; s_fs = '0; s_fd = '0; a_mode = 0; a_ma = 0; s_mode = 0; s_ma = 0;
        mq = 0; s_sync = 1'b0; pend = 1'b0;
        sbq.delete(); ackq.delete(); hist.delete();
        last_out = '0;
    endtask

    // One clock cycle: drive inputs, advance the model, push expectations.
    task automatic step(input bit e, input bit ld);
        int c, m, o;
        logic [ACC_W-1:0] dev, pc;
        bit apply;
        sb_t it;
        hist_t h;
        while (hist.size() > 0 && hist[0].t <= cyc - 3) begin
            mq = hist[0].m;
            void'(hist.pop_front());
        end
        en = e;
        cfg_load = ld;
        if (e) begin
            dev = mdev();
            pc  = m_phc + ((a_mode == 3) ? dev : '0);
            c   = msin(pc);
            m   = msin(m_phm);
            case (a_mode)
                0, 2, 3: o = c;
                1:       o = ((c * 16) + ((c * m) >>> 15) * a_ma) >>> 5;
                4:       o = m;
                default: o = 0;
            endcase
            it.val = o[OUT_W-1:0];
            it.due = cyc + 4;
            sbq.push_back(it);
            h.t = cyc;
            h.m = m;
            hist.push_back(h);
            apply = pend && !ld;
            if (apply && s_sync) begin
                m_phc = '0;
                m_phm = '0;
            end else begin
                m_phc = m_phc + ((a_mode == 2) ? a_fc + dev : a_fc);
                m_phm = m_phm + a_fs;
            end
            if (apply) begin
                a_mode = s_mode; a_fc = s_fc; a_fs = s_fs; a_fd = s_fd; a_ma = s_ma;
                pend = 1'b0;
                ackq.push_back(cyc + 1);
            end
        end
        if (ld) begin
            s_mode = int'(cfg_mode); s_fc = cfg_fc; s_fs = cfg_fs; s_fd = cfg_fd;
            s_ma = int'(cfg_ma); s_sync = cfg_sync; pend = 1'b1;
        end
        @(posedge clk);
        #1;
        en = 1'b0;
        cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        cfg_load = 1'b0;
        @(posedge clk);
        #1;
        clear_model();
        mon_on = 1'b1;
        check("rst_valid", sig_valid, 0);
        check("rst_out", sig_out, 0);
        check("rst_ack", cfg_ack, 0);
        rst = 1'b0;
    endtask

    sb_t mon_it;
    bit  exp_v, exp_a;

    always @(negedge clk) begin
        if (mon_on) begin
            exp_v = (sbq.size() > 0) && (sbq[0].due == cyc);
            check("valid", sig_valid, exp_v);
            if (exp_v) begin
                mon_it = sbq.pop_front();
                check("sample", sig_out, mon_it.val);
                last_out = mon_it.val;
            end else begin
                check("hold", sig_out, last_out);
            end
            exp_a = (ackq.size() > 0) && (ackq[0] == cyc);
            if (exp_a) void'(ackq.pop_front());
            check("ack", cfg_ack, exp_a);
        end
    end

    initial begin
        for (int k = 0; k < 2**LUT_AW; k++)
            lut[k] = $rtoi(32767.0 * $sin(3.141592653589793 * (real'(k) + 0.5) / 512.0) + 0.5);
        rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        do_reset();

        // Carrier quadrants
        set_cfg(0, 32'h4000_0000, 0, 0, 0, 0);
        step(0, 1);
        repeat (20) step(1, 0);

        // Pending / last load wins
        do_reset();
        set_cfg(0, 32'h2000_0000, 0, 0, 0, 0);
        step(0, 1);
        repeat (4) step(0, 0);
        set_cfg(0, 32'h4000_0000, 0, 0, 0, 0);
        step(0, 1);
        repeat (10) step(0, 0);
        repeat (16) step(1, 0);

        // AM at full index, then index 0 loaded on an en cycle
        set_cfg(1, 32'h4000_0000, 32'h1000_0000, 0, 15, 0);
        step(0, 1);
        repeat (40) step(1, 0);
        set_cfg(1, 32'h4000_0000, 32'h1000_0000, 0, 0, 0);
        step(1, 1);
        repeat (16) step(1, 0);

        // FM without deviation, then with deviation and gapped ticks
        set_cfg(2, 32'h4000_0000, 32'h1000_0000, 0, 0, 1);
        step(0, 1);
        repeat (16) step(1, 0);
        set_cfg(2, 32'h0300_0000, 32'h0040_0000, 32'h0100_0000, 0, 0);
        step(0, 1);
        repeat (200) step($urandom_range(0, 3) != 0, 0);

        // PM, tone, zero mode
        set_cfg(3, 32'h0100_0000, 32'h0080_0000, 32'h4000_0000, 0, 0);
        step(0, 1);
        repeat (150) step(1, 0);
        set_cfg(4, 32'h0100_0000, 32'h0123_4567, 0, 0, 0);
        step(0, 1);
        repeat (30) step(1, 0);
        set_cfg(6, 32'h0100_0000, 32'h0123_4567, 0, 0, 0);
        step(0, 1);
        repeat (8) step(1, 0);

        // Sync applied mid-run
        set_cfg(0, 32'h4000_0000, 32'h0800_0000, 0, 0, 1);
        repeat (5) step(1, 0);
        step(1, 1);
        repeat (12) step(1, 0);

        // Reset with samples in flight and a pending config
        repeat (2) step(1, 0);
        set_cfg(1, 32'h1000_0000, 32'h0100_0000, 0, 7, 0);
        step(1, 1);
        do_reset();
        repeat (8) step(0, 0);

        // Randomised traffic
        repeat (1500) begin
            bit ld;
            ld = ($urandom_range(0, 19) == 0);
            if (ld) set_cfg($urandom_range(0, 7), $urandom, $urandom, $urandom,
                            $urandom_range(0, 15), $urandom_range(0, 3) == 0);
            step($urandom_range(0, 2) != 0, ld);
        end
        repeat (8) step(0, 0);
        check("drain_samples", sbq.size(), 0);
        check("drain_acks", ackq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
